// File: rtl/srpt_pkg.sv
// Shared Homa grant definitions: packet/credit field layout, table entry and
// receiver FSM encoding. Also consumed by the grant packet generator.
package srpt_pkg;

    localparam int PEER_ID_W   = 14;
    localparam int RPC_ID_W    = 14;
    localparam int OFFSET_W    = 10;
    localparam int PRIO_W      = 3;
    localparam int GRANT_PKT_W = 51;

    // Grant packet bit positions
    localparam int GNT_PEER_LSB = 37;
    localparam int GNT_RPC_LSB  = 23;
    localparam int GNT_OFF_LSB  = 13;
    localparam int GNT_LEN_LSB  = 3;
    localparam int GNT_PRIO_LSB = 0;

    // Credit entry bit positions
    localparam int CRD_PEER_LSB = 37;
    localparam int CRD_RPC_LSB  = 23;
    localparam int CRD_NEW_LSB  = 13;
    localparam int CRD_PREV_LSB = 3;
    localparam int CRD_PRIO_LSB = 0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_UPDATE = 2'd2,
        S_STALL  = 2'd3
    } state_t;

    typedef struct packed {
        logic [PEER_ID_W-1:0] peer_id;
        logic [RPC_ID_W-1:0]  rpc_id;
        logic [OFFSET_W-1:0]  grant_offset;
        logic [OFFSET_W-1:0]  msg_len;
        logic [PRIO_W-1:0]    prio;
    } grant_pkt_t;

    typedef struct packed {
        logic [PEER_ID_W-1:0] peer_id;
        logic [RPC_ID_W-1:0]  rpc_id;
        logic [OFFSET_W-1:0]  new_granted;
        logic [OFFSET_W-1:0]  prev_granted;
        logic [PRIO_W-1:0]    prio;
    } credit_t;

    typedef struct packed {
        logic [RPC_ID_W-1:0] tag;
        logic [OFFSET_W-1:0] granted;
        logic [OFFSET_W-1:0] msg_len;
    } tbl_entry_t;

    function automatic logic [OFFSET_W-1:0] clamp_offset(
        input logic [OFFSET_W-1:0] off,
        input logic [OFFSET_W-1:0] len
    );
        return (off < len) ? off : len;
    endfunction

endpackage

// File: rtl/srpt_grant_rx_if.sv
// Grant input FIFO (FWFT) and credit output FIFO signals of the grant receiver.
interface srpt_grant_rx_if;
    import srpt_pkg::*;

    logic                   grant_in_empty_i;
    logic [GRANT_PKT_W-1:0] grant_in_data_i;
    logic                   grant_in_read_en_o;
    logic                   xmit_full_i;
    logic [GRANT_PKT_W-1:0] xmit_data_o;
    logic                   xmit_write_en_o;

    modport master (
        output grant_in_empty_i, grant_in_data_i, xmit_full_i,
        input  grant_in_read_en_o, xmit_data_o, xmit_write_en_o
    );

    modport slave (
        input  grant_in_empty_i, grant_in_data_i, xmit_full_i,
        output grant_in_read_en_o, xmit_data_o, xmit_write_en_o
    );

endinterface

// File: rtl/srpt_grant_table.sv
// Per-RPC grant state RAM: one write port, one read port with registered output.
module srpt_grant_table
    import srpt_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output tbl_entry_t               rd_data_o,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  tbl_entry_t               wr_data_i
);

    tbl_entry_t mem [DEPTH];
    tbl_entry_t rd_data_q;

    // Contents are not reset; the valid vector in the parent qualifies every read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data_i;
        if (rd_en) rd_data_q <= mem[rd_addr];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/srpt_grant_rx.sv
// Sender-side Homa GRANT receiver: tracks the highest granted offset per RPC
// and forwards a transmit-credit entry only when a grant widens the window.
module srpt_grant_rx
    import srpt_pkg::*;
#(
    parameter int TABLE_DEPTH = 64
) (
    input  logic           ap_clk,
    input  logic           ap_rst,
    srpt_grant_rx_if.slave bus,
    output logic [15:0]    drop_count_o,
    output logic           ap_idle
);

    localparam int IDX_W = $clog2(TABLE_DEPTH);

    state_t                 state_q, state_d;
    grant_pkt_t             pkt_q, pkt_d, pkt_in;
    tbl_entry_t             ent_q, ent_d, rd_ent, wr_ent;
    credit_t                cred_q, cred_d, cred;
    logic [TABLE_DEPTH-1:0] valid_q, valid_d;
    logic [15:0]            drop_q, drop_d;

    logic                pop, in_update, hit, grow, wr_en, drop;
    logic [OFFSET_W-1:0] eff, prev;
    logic [IDX_W-1:0]    rd_idx, wr_idx;

    assign pkt_in    = bus.grant_in_data_i;
    assign pop       = (state_q == S_IDLE) && !bus.grant_in_empty_i;
    assign in_update = (state_q == S_UPDATE);
    assign rd_idx    = pkt_in.rpc_id[IDX_W-1:0];
    assign wr_idx    = pkt_q.rpc_id[IDX_W-1:0];

    // prev reads as 0 for a new entry, so eff > prev decides emit for both
    // new entries and hits; only a hit that does not grow counts as a drop.
    assign eff   = clamp_offset(pkt_q.grant_offset, pkt_q.msg_len);
    assign hit   = valid_q[wr_idx] && (ent_q.tag == pkt_q.rpc_id);
    assign prev  = hit ? ent_q.granted : '0;
    assign grow  = eff > prev;
    assign drop  = in_update && hit && !grow;
    assign wr_en = in_update && (!hit || grow);

    assign wr_ent = '{tag:     pkt_q.rpc_id,
                      granted: eff,
                      msg_len: hit ? ent_q.msg_len : pkt_q.msg_len};

    assign cred = '{peer_id:      pkt_q.peer_id,
                    rpc_id:       pkt_q.rpc_id,
                    new_granted:  eff,
                    prev_granted: prev,
                    prio:         pkt_q.prio};

    srpt_grant_table #(
        .DEPTH (TABLE_DEPTH)
    ) u_table (
        .clk       (ap_clk),
        .rd_en     (pop),
        .rd_addr   (rd_idx),
        .rd_data_o (rd_ent),
        .wr_en     (wr_en),
        .wr_addr   (wr_idx),
        .wr_data_i (wr_ent)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (!bus.grant_in_empty_i) state_d = S_LOOKUP;
            S_LOOKUP: state_d = S_UPDATE;
            S_UPDATE: state_d = (grow && bus.xmit_full_i) ? S_STALL : S_IDLE;
            S_STALL:  if (!bus.xmit_full_i) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.grant_in_read_en_o = pop;
        bus.xmit_write_en_o    = 1'b0;
        bus.xmit_data_o        = cred_q;
        ap_idle                = (state_q == S_IDLE) && bus.grant_in_empty_i;
        case (state_q)
            S_UPDATE: begin
                bus.xmit_data_o     = cred;
                bus.xmit_write_en_o = grow && !bus.xmit_full_i;
            end
            S_STALL:  bus.xmit_write_en_o = !bus.xmit_full_i;
            default:  ;
        endcase
    end

    always_comb begin
        pkt_d   = pop ? pkt_in : pkt_q;
        ent_d   = (state_q == S_LOOKUP) ? rd_ent : ent_q;
        cred_d  = (in_update && grow) ? cred : cred_q;
        valid_d = valid_q;
        if (wr_en) valid_d[wr_idx] = 1'b1;
        drop_d  = drop_q;
        if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    end

    // Reset drops the in-flight packet and invalidates the whole table.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            pkt_q   <= '0;
            ent_q   <= '0;
            cred_q  <= '0;
            valid_q <= '0;
            drop_q  <= '0;
        end else begin
            pkt_q   <= pkt_d;
            ent_q   <= ent_d;
            cred_q  <= cred_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign drop_count_o = drop_q;

endmodule

// File: tb/tb_srpt_grant_rx.sv
// Bench for srpt_grant_rx: vector table plus stall and reset sequences,
// credit entries checked against a scoreboard of expected writes.
module tb_srpt_grant_rx;
    import srpt_pkg::*;

    logic        ap_clk;
    logic        ap_rst;
    logic [15:0] drop_count_o;
    logic        ap_idle;

    srpt_grant_rx_if bus();

    srpt_grant_rx #(.TABLE_DEPTH(64)) dut (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .bus          (bus),
        .drop_count_o (drop_count_o),
        .ap_idle      (ap_idle)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [13:0] peer;
        logic [13:0] rpc;
        logic [9:0]  off;
        logic [9:0]  len;
        logic [2:0]  prio;
        logic        emit;
        logic [9:0]  new_g;
        logic [9:0]  prev_g;
        logic [15:0] drops;
    } vec_t;

    vec_t        vecs[14];
    logic [50:0] in_q[$];
    logic [50:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        s_rd, s_wr;
    logic [50:0] s_data;

    function automatic logic [50:0] mk51(input logic [13:0] a, input logic [13:0] b,
                                         input logic [9:0] c, input logic [9:0] d,
                                         input logic [2:0] e);
        return {a, b, c, d, e};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_in();
        bus.grant_in_empty_i = (in_q.size() == 0);
        bus.grant_in_data_i  = (in_q.size() != 0) ? in_q[0] : '0;
    endtask

    // Called at a negedge: sample, clock once, then update the FWFT input model.
    task automatic step();
        logic [50:0] e;
        #1;
        s_rd   = bus.grant_in_read_en_o;
        s_wr   = bus.xmit_write_en_o;
        s_data = bus.xmit_data_o;
        check("pop_while_empty", 64'(s_rd && bus.grant_in_empty_i), 64'd0);
        check("push_while_full", 64'(s_wr && bus.xmit_full_i), 64'd0);
        if (s_wr) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(s_data), 64'd0 - 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("xmit_data", 64'(s_data), 64'(e));
            end
        end
        @(posedge ap_clk);
        #1;
        if (s_rd && in_q.size() != 0) void'(in_q.pop_front());
        drive_in();
        @(negedge ap_clk);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int rd_c, wr_c;
        in_q.push_back(mk51(v.peer, v.rpc, v.off, v.len, v.prio));
        if (v.emit) exp_q.push_back(mk51(v.peer, v.rpc, v.new_g, v.prev_g, v.prio));
        drive_in();
        rd_c = -1;
        wr_c = -1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (s_rd) rd_c = i;
            if (s_wr) wr_c = i;
        end
        check($sformatf("v%0d_pending", id), 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        check($sformatf("v%0d_drops", id), 64'(drop_count_o), 64'(v.drops));
        if (v.emit) check($sformatf("v%0d_latency", id), 64'(wr_c - rd_c), 64'd2);
    endtask

    initial begin
        int   bad;
        vec_t v;
        logic [50:0] e1;

        vecs[0]  = '{14'd1,     14'd1,     10'd5,    10'd10,   3'd2, 1'b1, 10'd5,    10'd0, 16'd0};
        vecs[1]  = '{14'd1,     14'd1,     10'd8,    10'd10,   3'd2, 1'b1, 10'd8,    10'd5, 16'd0};
        vecs[2]  = '{14'd1,     14'd1,     10'd8,    10'd10,   3'd2, 1'b0, 10'd0,    10'd0, 16'd1};
        vecs[3]  = '{14'd1,     14'd1,     10'd3,    10'd10,   3'd2, 1'b0, 10'd0,    10'd0, 16'd2};
        vecs[4]  = '{14'd2,     14'd2,     10'd20,   10'd12,   3'd1, 1'b1, 10'd12,   10'd0, 16'd2};
        vecs[5]  = '{14'd2,     14'd2,     10'd15,   10'd12,   3'd1, 1'b0, 10'd0,    10'd0, 16'd3};
        vecs[6]  = '{14'd9,     14'd3,     10'd4,    10'd10,   3'd0, 1'b1, 10'd4,    10'd0, 16'd3};
        vecs[7]  = '{14'd11,    14'd67,    10'd2,    10'd10,   3'd5, 1'b1, 10'd2,    10'd0, 16'd3};
        vecs[8]  = '{14'd9,     14'd3,     10'd4,    10'd10,   3'd0, 1'b1, 10'd4,    10'd0, 16'd3};
        vecs[9]  = '{14'd4,     14'd4,     10'd7,    10'd0,    3'd3, 1'b0, 10'd0,    10'd0, 16'd3};
        vecs[10] = '{14'd4,     14'd4,     10'd1,    10'd10,   3'd3, 1'b1, 10'd1,    10'd0, 16'd3};
        vecs[11] = '{14'd5,     14'd5,     10'd0,    10'd10,   3'd6, 1'b0, 10'd0,    10'd0, 16'd3};
        vecs[12] = '{14'd5,     14'd5,     10'd0,    10'd10,   3'd6, 1'b0, 10'd0,    10'd0, 16'd4};
        vecs[13] = '{14'd16383, 14'd16383, 10'd1023, 10'd1023, 3'd7, 1'b1, 10'd1023, 10'd0, 16'd4};

        ap_rst = 1'b1;
        bus.xmit_full_i = 1'b0;
        drive_in();
        repeat (2) @(negedge ap_clk);
        check("rst_read_en",  64'(bus.grant_in_read_en_o), 64'd0);
        check("rst_write_en", 64'(bus.xmit_write_en_o), 64'd0);
        check("rst_data",     64'(bus.xmit_data_o), 64'd0);
        check("rst_drops",    64'(drop_count_o), 64'd0);
        check("rst_idle",     64'(ap_idle), 64'd1);
        ap_rst = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        // Output FIFO full during an emit, with the next packet already queued
        e1 = mk51(14'd1, 14'd1, 10'd9, 10'd8, 3'd2);
        bus.xmit_full_i = 1'b1;
        in_q.push_back(mk51(14'd1, 14'd1, 10'd9, 10'd10, 3'd2));
        in_q.push_back(mk51(14'd3, 14'd6, 10'd3, 10'd10, 3'd4));
        exp_q.push_back(e1);
        exp_q.push_back(mk51(14'd3, 14'd6, 10'd3, 10'd0, 3'd4));
        drive_in();
        repeat (3) step();
        check("stall_update_data", 64'(s_data), 64'(e1));
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_data !== e1 || s_rd || s_wr) bad++;
        end
        check("stall_hold_bad_cycles", 64'(bad), 64'd0);
        bus.xmit_full_i = 1'b0;
        step();
        check("stall_release_write", 64'(s_wr), 64'd1);
        repeat (4) step();
        check("stall_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        check("stall_drops", 64'(drop_count_o), 64'd4);

        // Reset while stalled: the popped packet is lost, table invalidated
        bus.xmit_full_i = 1'b1;
        in_q.push_back(mk51(14'd1, 14'd1, 10'd10, 10'd10, 3'd2));
        drive_in();
        repeat (3) step();
        ap_rst = 1'b1;
        #1;
        check("mid_rst_write_en", 64'(bus.xmit_write_en_o), 64'd0);
        check("mid_rst_data",     64'(bus.xmit_data_o), 64'd0);
        check("mid_rst_drops",    64'(drop_count_o), 64'd0);
        check("mid_rst_idle",     64'(ap_idle), 64'd1);
        check("mid_rst_read_en",  64'(bus.grant_in_read_en_o), 64'd0);
        bus.xmit_full_i = 1'b0;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        v = '{14'd1, 14'd1, 10'd5, 10'd10, 3'd2, 1'b1, 10'd5, 10'd0, 16'd0};
        run_vec(v, 99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
